// File: rtl/or8_way_pkg.sv
// Shared gate-library helpers: fixed reduction width plus popcount and
// lowest-set-bit functions used by the 8-way OR reduction.
package or8_way_pkg;

   localparam int unsigned OR8_W = 8;

   function automatic logic [3:0] popcount8(input logic [OR8_W-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < OR8_W; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

   // Scanning downward leaves the lowest set index; 0 when v is empty.
   function automatic logic [2:0] lowest_set8(input logic [OR8_W-1:0] v);
      logic [2:0] idx;
      idx = '0;
      for (int i = OR8_W - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = 3'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/or8_reduce_comb.sv
// Purely combinational reduction of a masked 8-bit vector: any-set,
// popcount and lowest set index.
module or8_reduce_comb
   import or8_way_pkg::*;
(
   input  logic [OR8_W-1:0] m,
   output logic             any,
   output logic [3:0]       count,
   output logic [2:0]       first_idx
);

   assign any       = |m;
   assign count     = popcount8(m);
   assign first_idx = lowest_set8(m);

endmodule

// File: rtl/or8_way.sv
// 8-input masked OR reduction with registered out/count/first_idx and a
// one-cycle latency. Define OR8WAY_STICKY_EN to accumulate inputs over time.
module or8_way
   import or8_way_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [OR8_W-1:0] in,
   input  logic             in_valid,
   input  logic [OR8_W-1:0] mask,
   input  logic             clear,
   output logic             out,
   output logic             out_valid,
   output logic [2:0]       first_idx,
   output logic [3:0]       count
);

   logic [OR8_W-1:0] m;
   logic [OR8_W-1:0] red_src;
   logic             load_en;

   assign m = in & mask;

`ifdef OR8WAY_STICKY_EN
   logic [OR8_W-1:0] acc_q, acc_d;

   // Clear together with valid data restarts history from the new data.
   always_comb begin
      acc_d = acc_q;
      if (in_valid) begin
         acc_d = clear ? m : (acc_q | m);
      end else if (clear) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign red_src = acc_d;
   assign load_en = in_valid | clear;
`else
   logic unused_clear;
   assign unused_clear = clear;
   assign red_src      = m;
   assign load_en      = in_valid;
`endif

   logic       any_c;
   logic [3:0] count_c;
   logic [2:0] first_idx_c;

   or8_reduce_comb u_reduce (
      .m         (red_src),
      .any       (any_c),
      .count     (count_c),
      .first_idx (first_idx_c)
   );

   logic       out_q, out_d;
   logic       out_valid_q, out_valid_d;
   logic [2:0] first_idx_q, first_idx_d;
   logic [3:0] count_q, count_d;

   always_comb begin
      out_d       = out_q;
      first_idx_d = first_idx_q;
      count_d     = count_q;
      out_valid_d = in_valid;
      if (load_en) begin
         out_d       = any_c;
         first_idx_d = first_idx_c;
         count_d     = count_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q       <= 1'b0;
         out_valid_q <= 1'b0;
         first_idx_q <= '0;
         count_q     <= '0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         first_idx_q <= first_idx_d;
         count_q     <= count_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign first_idx = first_idx_q;
   assign count     = count_q;

endmodule

// File: tb/tb_or8_way.sv
// Directed self-checking bench for or8_way; expectations follow the
// OR8WAY_STICKY_EN setting of the build.
module tb_or8_way;

   logic       clk;
   logic       rst;
   logic [7:0] in;
   logic       in_valid;
   logic [7:0] mask;
   logic       clear;
   logic       out;
   logic       out_valid;
   logic [2:0] first_idx;
   logic [3:0] count;

   int tests;
   int fails;

   or8_way dut (
      .clk       (clk),
      .rst       (rst),
      .in        (in),
      .in_valid  (in_valid),
      .mask      (mask),
      .clear     (clear),
      .out       (out),
      .out_valid (out_valid),
      .first_idx (first_idx),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; clear = 1'b0; in = 8'h00; mask = 8'hFF;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in = 8'hFF; in_valid = 1'b1; mask = 8'hFF; clear = 1'b0;
      tick();
      tests++;
      if (out !== 1'b0 || count !== 4'd0 || out_valid !== 1'b0 || first_idx !== 3'd0) begin
         fails++;
         $display("FAIL reset: out=%b cnt=%0d ov=%b idx=%0d, want 0 0 0 0",
                  out, count, out_valid, first_idx);
      end
      tick();
      tests++;
      if (out !== 1'b0 || count !== 4'd0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_hold: out=%b cnt=%0d ov=%b, want 0 0 0", out, count, out_valid);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic_or();
      logic [7:0] vin  [5] = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h28};
      logic       eout [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [3:0] ecnt [5] = '{4'd0, 4'd1, 4'd1, 4'd8, 4'd2};
      logic [2:0] eidx [5] = '{3'd0, 3'd0, 3'd7, 3'd0, 3'd3};
      do_reset();
      mask = 8'hFF;
      // clear with valid makes each result history-free in either build
      for (int i = 0; i < 5; i++) begin
         in = vin[i]; in_valid = 1'b1; clear = 1'b1;
         tick();
         tests++;
         if (out !== eout[i] || count !== ecnt[i] || first_idx !== eidx[i] || out_valid !== 1'b1)
         begin
            fails++;
            $display("FAIL basic_or[%0d] in=%h: out=%b cnt=%0d idx=%0d ov=%b, want %b %0d %0d 1",
                     i, vin[i], out, count, first_idx, out_valid, eout[i], ecnt[i], eidx[i]);
         end
      end
      in_valid = 1'b0; clear = 1'b0;
   endtask

   task automatic test_mask();
      do_reset();
      in = 8'h0F; mask = 8'hF0; in_valid = 1'b1; clear = 1'b1;
      tick();
      tests++;
      if (out !== 1'b0 || count !== 4'd0 || first_idx !== 3'd0) begin
         fails++;
         $display("FAIL mask_f0: out=%b cnt=%0d idx=%0d, want 0 0 0", out, count, first_idx);
      end
      mask = 8'h0C;
      tick();
      tests++;
      if (out !== 1'b1 || count !== 4'd2 || first_idx !== 3'd2) begin
         fails++;
         $display("FAIL mask_0c: out=%b cnt=%0d idx=%0d, want 1 2 2", out, count, first_idx);
      end
      in = 8'hFF; mask = 8'h00;
      tick();
      tests++;
      if (out !== 1'b0 || count !== 4'd0) begin
         fails++;
         $display("FAIL mask_00: out=%b cnt=%0d, want 0 0", out, count);
      end
      in_valid = 1'b0; clear = 1'b0;
   endtask

   task automatic test_hold();
      do_reset();
      mask = 8'hFF; in = 8'h10; in_valid = 1'b1; clear = 1'b1;
      tick();
      tests++;
      if (out !== 1'b1 || first_idx !== 3'd4 || count !== 4'd1 || out_valid !== 1'b1) begin
         fails++;
         $display("FAIL hold_load: out=%b idx=%0d cnt=%0d ov=%b, want 1 4 1 1",
                  out, first_idx, count, out_valid);
      end
      in = 8'h00; in_valid = 1'b0; clear = 1'b0;
      tick();
      tests++;
      if (out !== 1'b1 || first_idx !== 3'd4 || count !== 4'd1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL hold_keep: out=%b idx=%0d cnt=%0d ov=%b, want 1 4 1 0",
                  out, first_idx, count, out_valid);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      mask = 8'hFF; in = 8'hFF; in_valid = 1'b1; clear = 1'b1;
      tick();
      rst = 1'b1; in = 8'h0F;
      tick();
      tests++;
      if (out !== 1'b0 || count !== 4'd0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: out=%b cnt=%0d ov=%b, want 0 0 0", out, count, out_valid);
      end
      rst = 1'b0; in = 8'h02;
      tick();
      tests++;
      if (out !== 1'b1 || count !== 4'd1 || first_idx !== 3'd1 || out_valid !== 1'b1) begin
         fails++;
         $display("FAIL after_reset: out=%b cnt=%0d idx=%0d ov=%b, want 1 1 1 1",
                  out, count, first_idx, out_valid);
      end
      in_valid = 1'b0; clear = 1'b0;
   endtask

   task automatic test_sticky();
      logic [3:0] exp_cnt2;
      logic [2:0] exp_idx2;
`ifdef OR8WAY_STICKY_EN
      exp_cnt2 = 4'd2; exp_idx2 = 3'd0;
`else
      exp_cnt2 = 4'd1; exp_idx2 = 3'd7;
`endif
      do_reset();
      mask = 8'hFF; in = 8'h01; in_valid = 1'b1; clear = 1'b0;
      tick();
      tests++;
      if (count !== 4'd1 || first_idx !== 3'd0 || out !== 1'b1) begin
         fails++;
         $display("FAIL sticky_first: cnt=%0d idx=%0d out=%b, want 1 0 1", count, first_idx, out);
      end
      in = 8'h80;
      tick();
      tests++;
      if (count !== exp_cnt2 || first_idx !== exp_idx2) begin
         fails++;
         $display("FAIL sticky_accum: cnt=%0d idx=%0d, want %0d %0d",
                  count, first_idx, exp_cnt2, exp_idx2);
      end
      in = 8'h04; clear = 1'b1;
      tick();
      tests++;
      if (count !== 4'd1 || first_idx !== 3'd2 || out !== 1'b1) begin
         fails++;
         $display("FAIL sticky_clear_valid: cnt=%0d idx=%0d out=%b, want 1 2 1",
                  count, first_idx, out);
      end
      in_valid = 1'b0; in = 8'hFF;
      tick();
      tests++;
`ifdef OR8WAY_STICKY_EN
      if (count !== 4'd0 || first_idx !== 3'd0 || out !== 1'b0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL sticky_clear_only: cnt=%0d idx=%0d out=%b ov=%b, want 0 0 0 0",
                  count, first_idx, out, out_valid);
      end
`else
      if (count !== 4'd1 || first_idx !== 3'd2 || out !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL clear_ignored: cnt=%0d idx=%0d out=%b ov=%b, want 1 2 1 0",
                  count, first_idx, out, out_valid);
      end
`endif
      clear = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1; in = 8'h00; in_valid = 1'b0; mask = 8'hFF; clear = 1'b0;
      #1;
      test_reset();
      test_basic_or();
      test_mask();
      test_hold();
      test_mid_reset();
      test_sticky();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
